// File: rtl/fmap_sram_reader.sv
// fmap_sram_reader
//   Streaming read front-end for the feature-map two-port SRAM. A start
//   command launches a run of reads on the SRAM read port, the one-cycle
//   read latency is absorbed, and the words leave as a valid/ready stream.
//   A 2-entry output buffer holds in-flight data under backpressure.
//
// Ports
//   CLK        single clock, rising edge
//   RSTN       asynchronous active-low reset
//   start      one-cycle command pulse, sampled only while busy=0
//   base_addr  first read address (sampled with start)
//   length     number of words, 0..2^ADDR_BITS (sampled with start)
//   stride     address increment (only with READER_STRIDE_EN)
//   busy       run in progress
//   done       one-cycle pulse at end of run
//   CENA/AA    SRAM read enable (active-high) / read address
//   QA         SRAM read data, valid the cycle after CENA=1
//   out_valid/out_ready/out_data/out_last  output stream
//
// Configuration
//   READER_STRIDE_EN  defined: stride port present, address advances by the
//                     latched stride. Undefined: increment fixed at 1.

module fmap_sram_reader #(
  parameter int ADDR_BITS = 13,
  parameter int DATA_BITS = 16
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [ADDR_BITS:0]   length,
`ifdef READER_STRIDE_EN
  input  logic [ADDR_BITS-1:0] stride,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 CENA,
  output logic [ADDR_BITS-1:0] AA,
  input  logic [DATA_BITS-1:0] QA,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_last
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [ADDR_BITS:0]   REM_ONE   = 1;
  localparam logic [ADDR_BITS-1:0] UNIT_STEP = 1;

  state_t                 state;
  logic [ADDR_BITS-1:0]   addr;
  logic [ADDR_BITS:0]     remaining;
  logic [ADDR_BITS-1:0]   step;
`ifdef READER_STRIDE_EN
  logic [ADDR_BITS-1:0]   stride_r;
`endif
  logic                   inflight;
  logic                   inflight_last;
  logic                   done_r;

  logic [DATA_BITS-1:0]   buf_data [2];
  logic                   buf_last [2];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [1:0]             fifo_count;

  logic                   pop;
  logic [2:0]             occ;
  logic                   room;
  logic                   issue;
  logic                   drained;

`ifdef READER_STRIDE_EN
  assign step = stride_r;
`else
  assign step = UNIT_STEP;
`endif

  // Issue only if the buffer can still take every word already committed:
  // buffered + in flight - leaving this cycle must stay below 2.
  always_comb begin
    pop     = (fifo_count != 2'd0) && out_ready;
    occ     = {1'b0, fifo_count} + {2'b00, inflight};
    room    = (occ < 3'd2) || ((occ == 3'd2) && pop);
    issue   = (state == READ) && room;
    // Ending in the same cycle as the final pop makes done land one
    // cycle after the out_last handshake.
    drained = (state == DRAIN) && !inflight &&
              ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state         <= IDLE;
      addr          <= '0;
      remaining     <= '0;
`ifdef READER_STRIDE_EN
      stride_r      <= '0;
`endif
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done_r        <= 1'b0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      fifo_count    <= 2'd0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_last[i] <= 1'b0;
      end
    end else begin
      done_r        <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue && (remaining == REM_ONE);

      if (inflight) begin
        buf_data[wr_ptr] <= QA;
        buf_last[wr_ptr] <= inflight_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({inflight, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase

      case (state)
        IDLE: begin
          if (start) begin
            addr      <= base_addr;
            remaining <= length;
`ifdef READER_STRIDE_EN
            stride_r  <= stride;
`endif
            // Zero-length run has nothing to drain: finish now.
            if (length == '0) begin
              done_r <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (issue) begin
            addr      <= addr + step;
            remaining <= remaining - REM_ONE;
            if (remaining == REM_ONE) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drained) begin
            done_r <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = done_r;
  assign CENA      = issue;
  assign AA        = issue ? addr : '0;
  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = out_valid ? buf_data[rd_ptr] : '0;
  assign out_last  = out_valid ? buf_last[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_fmap_sram_reader.sv
// tb_fmap_sram_reader
//   Bench for fmap_sram_reader: SRAM model with one-cycle read latency,
//   table of runs, address/data scoreboards, and hand-written sequences for
//   mid-run reset, start-while-busy and (if enabled) stride runs.

module tb_fmap_sram_reader;

    localparam int AW = 13;
    localparam int DW = 16;

    logic          CLK;
    logic          RSTN;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic [AW-1:0] stride;
    logic          busy;
    logic          done;
    logic          CENA;
    logic [AW-1:0] AA;
    logic [DW-1:0] QA;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    fmap_sram_reader #(
        .ADDR_BITS(AW),
        .DATA_BITS(DW)
    ) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
`ifdef READER_STRIDE_EN
        .stride    (stride),
`endif
        .busy      (busy),
        .done      (done),
        .CENA      (CENA),
        .AA        (AA),
        .QA        (QA),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    always @(posedge CLK) cyc = cyc + 1;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {3'b000, a} ^ 16'hA5A5;
    endfunction

    // SRAM read port: data appears the cycle after CENA.
    always @(posedge CLK) begin
        if (CENA) QA <= mem_word(AA);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec = nvec + 1;
        if (act !== exp) begin
            nerr = nerr + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboards: expected addresses and {last,data} beats.
    logic [AW-1:0] aq [$];
    logic [DW:0]   eq [$];
    int            pend       = 0;
    int            first_cena = -1;
    int            first_beat = -1;
    int            ready_mode = 0;  // 0 high, 1 toggle, 2 low

    always @(posedge CLK) begin
        #1;
        if (ready_mode == 1) out_ready = ~out_ready;
    end

    always @(negedge CLK) begin
        logic pop;
        logic [DW:0] e;
        if (RSTN) begin
            pop = out_valid && out_ready;
            if (CENA) begin
                if (first_cena < 0) first_cena = cyc;
                chk("issue_room", ((pend - (pop ? 1 : 0)) < 2) ? 32'd1 : 32'd0, 32'd1);
                if (aq.size() == 0) begin
                    chk("unexpected_read", 32'd1, 32'd0);
                end else begin
                    chk("AA", 32'(AA), 32'(aq.pop_front()));
                end
            end
            if (pop) begin
                if (first_beat < 0) first_beat = cyc;
                if (eq.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e = eq.pop_front();
                    chk("beat", {15'd0, out_last, out_data}, {15'd0, e});
                end
            end
            pend = pend + (CENA ? 1 : 0) - (pop ? 1 : 0);
        end
    end

    task automatic push_expect(input logic [AW-1:0] b, input logic [AW:0] n, input logic [AW-1:0] s);
        logic [AW-1:0] a;
        logic [AW-1:0] st;
`ifdef READER_STRIDE_EN
        st = s;
`else
        st = 13'd1;
`endif
        a = b;
        for (int i = 0; i < int'(n); i++) begin
            aq.push_back(a);
            eq.push_back({(i == int'(n) - 1), mem_word(a)});
            a = a + st;
        end
    endtask

    task automatic run(input logic [AW-1:0] b, input logic [AW:0] n, input logic [AW-1:0] s,
                       input int mode, input int exp_lat, input bit poke);
        int t;
        bit got;
        ready_mode = mode;
        out_ready  = (mode != 2);
        first_cena = -1;
        first_beat = -1;
        @(posedge CLK); #1;
        t = cyc;
        start = 1'b1; base_addr = b; length = n; stride = s;
        push_expect(b, n, s);
        @(posedge CLK); #1;
        start = 1'b0;
        @(negedge CLK);
        chk("busy_after_start", 32'(busy), (n != 0) ? 32'd1 : 32'd0);
        if (poke) begin
            // Second start while busy must leave the run untouched.
            @(posedge CLK); #1;
            start = 1'b1; base_addr = 13'h0777; length = 14'd5;
            @(posedge CLK); #1;
            start = 1'b0;
            @(negedge CLK);
        end
        got = 1'b0;
        for (int k = 0; k < 20000 && !got; k++) begin
            if (done) got = 1'b1;
            else @(negedge CLK);
        end
        chk("done_seen", 32'(got), 32'd1);
        if (got) begin
            chk("busy_at_done", 32'(busy), 32'd0);
            if (exp_lat > 0) chk("done_latency", 32'(cyc - t), 32'(exp_lat));
            if (mode == 0 && n != 0) begin
                chk("first_cena_latency", 32'(first_cena - t), 32'd1);
                chk("first_beat_latency", 32'(first_beat - t), 32'd3);
            end
            if (n == 0) chk("no_cena_len0", (first_cena < 0) ? 32'd1 : 32'd0, 32'd1);
            chk("beats_left", 32'(eq.size()), 32'd0);
            chk("reads_left", 32'(aq.size()), 32'd0);
            @(negedge CLK);
            chk("done_pulse", 32'(done), 32'd0);
        end
    endtask

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   len;
        logic [AW-1:0] stride;
        int            mode;
        int            exp_lat;  // 0: not checked
        bit            poke;
    } vec_t;

    vec_t vt [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{13'h0000, 14'd100,  13'd1, 0, 103,  1'b1};
        vt[1] = '{13'h000A, 14'd8,    13'd1, 1, 0,    1'b0};
        vt[2] = '{13'h1FFE, 14'd4,    13'd1, 0, 7,    1'b0};
        vt[3] = '{13'h0000, 14'd0,    13'd1, 0, 1,    1'b0};
        vt[4] = '{13'h0123, 14'd1,    13'd1, 0, 4,    1'b0};
        vt[5] = '{13'h1FFF, 14'd3,    13'd1, 1, 0,    1'b0};
        vt[6] = '{13'h1000, 14'd8192, 13'd1, 0, 8195, 1'b0};

        RSTN = 1'b0; start = 1'b0; base_addr = '0; length = '0; stride = '0;
        out_ready = 1'b1; QA = '0;
        #1;
        chk("reset_outputs", {busy, done, CENA, out_valid, out_last, AA, out_data}, 32'd0);
        repeat (3) @(posedge CLK);
        @(negedge CLK) RSTN = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run(vt[i].base, vt[i].len, vt[i].stride, vt[i].mode, vt[i].exp_lat, vt[i].poke);
        end

        // Mid-run reset with two words held in the buffer.
        ready_mode = 2; out_ready = 1'b0;
        @(posedge CLK); #1;
        start = 1'b1; base_addr = 13'd300; length = 14'd10;
        push_expect(13'd300, 14'd10, 13'd1);
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        chk("held_valid", 32'(out_valid), 32'd1);
        chk("held_data", {15'd0, out_last, out_data}, {16'd0, mem_word(13'd300)});
        chk("held_pending", 32'(pend), 32'd2);
        chk("held_no_cena", 32'(CENA), 32'd0);
        @(posedge CLK); #3;
        RSTN = 1'b0;
        #1;
        chk("async_reset_outputs", {busy, done, CENA, out_valid, out_last, AA, out_data}, 32'd0);
        aq.delete(); eq.delete(); pend = 0;
        @(negedge CLK);
        @(negedge CLK) RSTN = 1'b1;
        chk("post_reset_idle", {busy, out_valid}, 32'd0);
        run(13'd500, 14'd5, 13'd1, 0, 8, 1'b0);

`ifdef READER_STRIDE_EN
        run(13'd4, 14'd5, 13'd3, 0, 8, 1'b0);
        run(13'd4, 14'd5, 13'd0, 1, 0, 1'b0);
        run(13'h1FF0, 14'd6, 13'h0800, 0, 9, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
